// File: rtl/bloom_bucket_rotator.sv
// Advances the insert bucket of a time-decaying Bloom filter on each timer pulse and zero-fills the reused bucket.
// Optional BLOOM_ROTATOR_STATS_EN adds rotation_count / dropped_count outputs.
module bloom_bucket_rotator #(
  parameter int  NUM_BUCKETS       = 4,
  parameter int  BUCKET_ADDR_WIDTH = 10,
  localparam int BUCKET_IDX_WIDTH  = (NUM_BUCKETS > 2) ? $clog2(NUM_BUCKETS) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         update,
  output logic [BUCKET_IDX_WIDTH-1:0]  cur_bucket,
  output logic                         busy,
  output logic                         clr_wr_req,
  input  logic                         clr_wr_gnt,
  output logic [BUCKET_IDX_WIDTH-1:0]  clr_bucket,
  output logic [BUCKET_ADDR_WIDTH-1:0] clr_addr,
  output logic                         rotate_done,
  output logic                         overflow
`ifdef BLOOM_ROTATOR_STATS_EN
  ,
  output logic [31:0]                  rotation_count,
  output logic [15:0]                  dropped_count
`endif
);

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

  localparam logic [BUCKET_IDX_WIDTH-1:0]  LAST_BUCKET = BUCKET_IDX_WIDTH'(NUM_BUCKETS - 1);
  localparam logic [BUCKET_ADDR_WIDTH-1:0] LAST_ADDR   = '1;

  state_t                      state;
  logic                        pending;
  logic                        upd;
  logic [BUCKET_IDX_WIDTH-1:0] next_bucket;

  assign upd = update & enable;
  // Explicit wrap compare so a non-power-of-two bucket count never reaches an unused index.
  assign next_bucket = (cur_bucket == LAST_BUCKET) ? '0 : cur_bucket + 1'b1;

  // NOTE: every state register uses <= so all flops sample pre-edge values, whatever the statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cur_bucket  <= '0;
      clr_bucket  <= '0;
      clr_addr    <= '0;
      busy        <= 1'b0;
      clr_wr_req  <= 1'b0;
      rotate_done <= 1'b0;
      overflow    <= 1'b0;
      pending     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          rotate_done <= 1'b0;
          if (upd || pending) begin
            cur_bucket <= next_bucket;
            clr_bucket <= next_bucket;
            clr_addr   <= '0;
            pending    <= 1'b0;
            busy       <= 1'b1;
            clr_wr_req <= 1'b1;
            state      <= CLEAR;
          end
        end
        CLEAR: begin
          if (clr_wr_gnt) begin
            if (clr_addr == LAST_ADDR) begin
              clr_addr    <= '0;
              clr_wr_req  <= 1'b0;
              rotate_done <= 1'b1;
              state       <= DONE;
            end else begin
              clr_addr <= clr_addr + 1'b1;
            end
          end
        end
        DONE: begin
          rotate_done <= 1'b0;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Queue depth is one: a second update while busy is dropped and flagged.
      if (state != IDLE && upd) begin
        if (pending) overflow <= 1'b1;
        else         pending  <= 1'b1;
      end
    end
  end

`ifdef BLOOM_ROTATOR_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rotation_count <= '0;
      dropped_count  <= '0;
    end else begin
      if (state == DONE) rotation_count <= rotation_count + 32'd1;
      if (state != IDLE && upd && pending && dropped_count != 16'hFFFF)
        dropped_count <= dropped_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bloom_bucket_rotator.sv
// Directed bench for bloom_bucket_rotator with write/done scoreboards (NUM_BUCKETS=3, BUCKET_ADDR_WIDTH=3).
module tb_bloom_bucket_rotator;
  localparam int NB = 3;
  localparam int AW = 3;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          reset, enable, update, clr_wr_gnt;
  logic [IW-1:0] cur_bucket, clr_bucket;
  logic [AW-1:0] clr_addr;
  logic          busy, clr_wr_req, rotate_done, overflow;
`ifdef BLOOM_ROTATOR_STATS_EN
  logic [31:0]   rotation_count;
  logic [15:0]   dropped_count;
`endif

  int vectors     = 0;
  int miscompares = 0;
  int exp_wr[$];
  int exp_done[$];

  always #5 clk = ~clk;

  bloom_bucket_rotator #(.NUM_BUCKETS(NB), .BUCKET_ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .update(update),
    .cur_bucket(cur_bucket), .busy(busy), .clr_wr_req(clr_wr_req), .clr_wr_gnt(clr_wr_gnt),
    .clr_bucket(clr_bucket), .clr_addr(clr_addr), .rotate_done(rotate_done), .overflow(overflow)
`ifdef BLOOM_ROTATOR_STATS_EN
    , .rotation_count(rotation_count), .dropped_count(dropped_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    vectors++;
    assert (obs === want) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  // Write scoreboard: every granted clear write must match the next expected {bucket, addr}.
  always @(negedge clk) begin : wr_monitor
    int e;
    if (!reset && clr_wr_req && clr_wr_gnt) begin
      check("wr_expected", exp_wr.size() > 0, 1);
      if (exp_wr.size() > 0) begin
        e = exp_wr.pop_front();
        check("wr_bucket_addr", {clr_bucket, clr_addr}, e);
      end
    end
  end

  always @(negedge clk) begin : done_monitor
    int e;
    if (!reset && rotate_done) begin
      check("done_expected", exp_done.size() > 0, 1);
      if (exp_done.size() > 0) begin
        e = exp_done.pop_front();
        check("done_clr_bucket", clr_bucket, e);
        check("done_cur_bucket", cur_bucket, e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    update = 1'b1;
    tick();
    update = 1'b0;
  endtask

  task automatic expect_rotation(input int b);
    for (int a = 0; a < (1 << AW); a++) exp_wr.push_back((b << AW) | a);
    exp_done.push_back(b);
  endtask

  task automatic wait_done(input bit stall, output int cycles);
    cycles = 0;
    clr_wr_gnt = stall ? 1'b0 : 1'b1;
    while (!rotate_done && cycles < 200) begin
      tick();
      cycles++;
      if (stall) clr_wr_gnt = ~clr_wr_gnt;
    end
    check("done_in_budget", rotate_done, 1);
    clr_wr_gnt = 1'b1;
  endtask

  task automatic rotate(input int b, input bit stall, input int exp_cycles);
    int cycles;
    expect_rotation(b);
    pulse();
    check("start_cur_bucket", cur_bucket, b);
    check("start_busy", busy, 1);
    check("start_req", clr_wr_req, 1);
    wait_done(stall, cycles);
    check("clear_cycles", cycles, exp_cycles);
    check("done_busy", busy, 1);
    tick();
    check("done_one_cycle", rotate_done, 0);
    check("idle_busy", busy, 0);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: observed time limit expected completion");
    $fatal(1, "time limit reached");
  end

  initial begin : stimulus
    int cycles;
    int n;
    reset = 1'b1; enable = 1'b1; update = 1'b0; clr_wr_gnt = 1'b1;
    #12 reset = 1'b0;
    tick();
    check("rst_cur_bucket", cur_bucket, 0);
    check("rst_clr_bucket", clr_bucket, 0);
    check("rst_clr_addr", clr_addr, 0);
    check("rst_busy", busy, 0);
    check("rst_req", clr_wr_req, 0);
    check("rst_done", rotate_done, 0);
    check("rst_overflow", overflow, 0);

    // Basic rotation and non-power-of-two wrap: 1, 2, 0.
    rotate(1, 1'b0, 8);
    rotate(2, 1'b0, 8);
    rotate(0, 1'b0, 8);
    check("wrap_cur_bucket", cur_bucket, 0);

    // Grant stalled on alternate cycles: twice as many CLEAR cycles.
    rotate(1, 1'b1, 16);
    check("stall_writes_all", exp_wr.size(), 0);

    // Queued second update, then a third that overflows.
    expect_rotation(2);
    expect_rotation(0);
    pulse();
    check("q_cur_bucket", cur_bucket, 2);
    tick(); tick();
    pulse();
    check("q_no_overflow", overflow, 0);
    pulse();
    check("q_overflow", overflow, 1);
    wait_done(1'b0, cycles);
    check("q_first_cycles", cycles, 4);
    tick();
    check("q_gap_busy", busy, 0);
    check("q_gap_cur", cur_bucket, 2);
    tick();
    check("q_second_busy", busy, 1);
    check("q_second_cur", cur_bucket, 0);
    wait_done(1'b0, cycles);
    check("q_second_cycles", cycles, 8);
    tick();
    repeat (5) tick();
    check("q_only_two_busy", busy, 0);
    check("q_only_two_cur", cur_bucket, 0);
    check("q_done_drained", exp_done.size(), 0);
    check("q_overflow_sticky", overflow, 1);

    // Reset clears overflow; enable=0 ignores updates.
    reset = 1'b1; #2; reset = 1'b0;
    tick();
    check("rst2_overflow", overflow, 0);
    enable = 1'b0;
    pulse(); pulse(); tick(); pulse();
    tick(); tick();
    check("en0_cur_bucket", cur_bucket, 0);
    check("en0_busy", busy, 0);
    enable = 1'b1;
    tick();
    check("en0_no_pending", busy, 0);

    // Async reset at clr_addr=4: only addresses 0..3 are written.
    for (int a = 0; a < 4; a++) exp_wr.push_back((1 << AW) | a);
    pulse();
    n = 0;
    while (clr_addr != 3'd4 && n < 50) begin tick(); n++; end
    check("reached_addr4", clr_addr, 4);
    #2 reset = 1'b1;
    #1;
    check("arst_cur_bucket", cur_bucket, 0);
    check("arst_clr_bucket", clr_bucket, 0);
    check("arst_clr_addr", clr_addr, 0);
    check("arst_busy", busy, 0);
    check("arst_req", clr_wr_req, 0);
    check("arst_done", rotate_done, 0);
    check("arst_overflow", overflow, 0);
    check("arst_writes", exp_wr.size(), 0);
    tick();
    reset = 1'b0;
    tick();

`ifdef BLOOM_ROTATOR_STATS_EN
    check("stats_rst_rot", rotation_count, 0);
    check("stats_rst_drop", dropped_count, 0);
    expect_rotation(1);
    expect_rotation(2);
    pulse(); pulse(); pulse();
    wait_done(1'b0, cycles);
    tick(); tick();
    wait_done(1'b0, cycles);
    tick();
    rotate(0, 1'b0, 8);
    rotate(1, 1'b0, 8);
    rotate(2, 1'b0, 8);
    check("stats_rot", rotation_count, 5);
    check("stats_drop", dropped_count, 1);
    check("stats_cur", cur_bucket, 2);
`endif

    check("final_wr_drained", exp_wr.size(), 0);
    check("final_done_drained", exp_done.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bloom_bucket_rotator.md
Name: bloom_bucket_rotator

Overview:
- Consumer of the periodic `update` pulse produced by the bucket-timer (watchdog) block.
- On each pulse it advances the current insert bucket of the time-decaying Bloom filter.
- It then clears the reused (oldest) bucket by walking every entry through a shared memory write port, under a request/grant handshake.
- It tracks update pulses that arrive while a clear is in progress, so no rotation is lost silently.

Parameters:
- NUM_BUCKETS, 4: number of buckets; must be >= 2; need not be a power of two.
- BUCKET_ADDR_WIDTH, 10: per-bucket entry address width; a bucket holds 2**BUCKET_ADDR_WIDTH entries.
- BUCKET_IDX_WIDTH, log2(NUM_BUCKETS) (minimum 1): derived localparam, not overridable.

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-high; all state clears immediately on assertion.
- enable  in  1  when 0, a new update is neither accepted nor queued; an in-progress clear still completes.
- update  in  1  one-cycle rotation request from the timer.
- cur_bucket  out  BUCKET_IDX_WIDTH  bucket the datapath inserts into.
- busy  out  1  high while state is not IDLE; datapath must not insert or query cur_bucket while high.
- clr_wr_req  out  1  clear-write request to the memory arbiter.
- clr_wr_gnt  in  1  arbiter grant; a write occurs in any cycle where clr_wr_req and clr_wr_gnt are both 1.
- clr_bucket  out  BUCKET_IDX_WIDTH  bucket being cleared.
- clr_addr  out  BUCKET_ADDR_WIDTH  entry being cleared; write data is implicitly all-zero.
- rotate_done  out  1  one-cycle pulse when a clear finishes.
- overflow  out  1  sticky error flag; cleared only by reset.

Behaviour:
- Reset values: cur_bucket=0, clr_bucket=0, clr_addr=0, busy=0, clr_wr_req=0, rotate_done=0, overflow=0, pending=0, state=IDLE.
- FSM states: IDLE, CLEAR, DONE. busy = (state != IDLE). clr_wr_req = (state == CLEAR).
- IDLE:
  - Starts a rotation when (update & enable) or pending.
  - At that clock edge: cur_bucket <= (cur_bucket == NUM_BUCKETS-1) ? 0 : cur_bucket+1; clr_bucket <= the same new value; clr_addr <= 0; pending <= 0; state <= CLEAR.
  - Wrap uses an explicit compare, never modulo-2**n, so non-power-of-two NUM_BUCKETS works.
- CLEAR:
  - clr_addr increments only on cycles where clr_wr_gnt=1.
  - Granted write at clr_addr == all-ones: state <= DONE, clr_addr <= 0.
  - With clr_wr_gnt tied to 1, CLEAR lasts exactly 2**BUCKET_ADDR_WIDTH cycles.
- DONE:
  - rotate_done=1 for exactly one cycle.
  - Next state is always IDLE.
  - If pending=1, the next rotation starts at the IDLE cycle that follows (one IDLE cycle between rotations).
- Latency: update sampled at edge E -> rotate_done high during cycle E + 2**BUCKET_ADDR_WIDTH + 1, assuming full grant.
- Update while busy (CLEAR or DONE) with enable=1:
  - pending=0: set pending=1.
  - pending=1: set overflow=1; the extra update is dropped (queue depth is one).
- update while enable=0: ignored in every state; does not affect pending.
- Reset asserted mid-CLEAR: clear aborts, outputs return to reset values. Bucket contents are then undefined; the system flushes memory separately.

Optional Feature:
- Macro: BLOOM_ROTATOR_STATS_EN.
- When defined, two extra outputs are added:
  - rotation_count [31:0]: increments on each rotate_done; wraps from 0xFFFFFFFF to 0.
  - dropped_count [15:0]: increments on each overflow event; saturates at 0xFFFF.
  - Both reset to 0.
- When undefined: neither port nor counter logic exists; all other behaviour is identical.

Test Plan:
- Test parameters: NUM_BUCKETS=3, BUCKET_ADDR_WIDTH=3, clr_wr_gnt=1.
- Basic rotation: one update pulse -> cur_bucket 0->1, clr_bucket=1, clr_addr sequence 0..7 over 8 cycles, rotate_done pulse one cycle later, busy low after that.
- Non-power-of-two wrap: three rotations -> cur_bucket 1, 2, 0; never 3.
- Grant stall: clr_wr_gnt low on alternate cycles -> each clr_addr value held until granted, 16 CLEAR cycles, all 8 addresses written exactly once.
- Queued update: second update mid-CLEAR -> pending set, one IDLE cycle after rotate_done, second rotation to bucket 2, overflow=0. A third update during that same first clear -> overflow=1, only two rotations occur.
- Reset/enable: enable=0 with update pulses -> no change. Async reset asserted at clr_addr=4 -> all outputs 0 immediately, without waiting for a clock edge.
- With BLOOM_ROTATOR_STATS_EN defined: 5 rotations plus 1 drop -> rotation_count=5, dropped_count=1.
